// File: rtl/uart_sim_pkg.sv
// uart_sim_pkg: shared UART sim types (FSM states, data width) and baud divisor helper
package uart_sim_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int baud_val(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; ports req, pointer (highest priority index), enable, one-hot gnt
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (enable && !found && req[j] && j >= int'(pointer)) begin
        gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (enable && !found && req[j]) begin
        gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_sim_tx_arbiter.sv
// uart_sim_tx_arbiter: round-robin share of one 8N1 tx line; ports clk_i, rst_i, req_valid_i/req_data_i in, req_ready_o, grant_o, busy_o, txd_o out
module uart_sim_tx_arbiter
  import uart_sim_pkg::*;
#(
  parameter int BAUD_RATE  = 19200,
  parameter int CLOCK_FREQ = 100000000,
  parameter int NUM_REQ    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   txd_o
);
  localparam int BAUD_VAL = baud_val(CLOCK_FREQ, BAUD_RATE);
  localparam int BW = $clog2(BAUD_VAL);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  uart_state_t state;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [7:0] win_data;
  logic baud_done;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid_i),
    .pointer(ptr),
    .enable(state == IDLE && !rst_i),
    .gnt(req_ready_o)
  );
  always_comb begin
    win = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) begin
        win = PW'(i);
        win_data = req_data_i[8*i +: 8];
      end
    end
  end
  assign baud_done = baud_cnt == '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      txd_o <= 1'b1;
      busy_o <= 1'b0;
      grant_o <= '0;
      ptr <= '0;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd_o <= 1'b1;
          if (|req_ready_o) begin
            shreg <= win_data;
            grant_o <= req_ready_o;
            ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            busy_o <= 1'b1;
            baud_cnt <= BW'(BAUD_VAL - 1);
            txd_o <= 1'b0;
            state <= START;
          end
        end
        START: begin
          baud_cnt <= baud_done ? BW'(BAUD_VAL - 1) : baud_cnt - 1'b1;
          if (baud_done) begin
            bit_cnt <= '0;
            txd_o <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          baud_cnt <= baud_done ? BW'(BAUD_VAL - 1) : baud_cnt - 1'b1;
          if (baud_done) begin
            shreg <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            txd_o <= (bit_cnt == 3'(UART_DATA_BITS - 1)) ? 1'b1 : shreg[1];
            state <= (bit_cnt == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
          end
        end
        default: begin
          baud_cnt <= baud_done ? baud_cnt : baud_cnt - 1'b1;
          if (baud_done) begin
            grant_o <= '0;
            busy_o <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sim_tx_arbiter.sv
// tb_uart_sim_tx_arbiter: randomized + directed bench with frame-timing model and serial receiver
module tb_uart_sim_tx_arbiter;
  localparam int N = 4;
  localparam int BV = 10;
  localparam int FRAME = 10 * BV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] valid = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0] ready;
  logic [N-1:0] grant;
  logic busy;
  logic txd;
  uart_sim_tx_arbiter #(.BAUD_RATE(10), .CLOCK_FREQ(100), .NUM_REQ(N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(valid),
    .req_data_i(data),
    .req_ready_o(ready),
    .grant_o(grant),
    .busy_o(busy),
    .txd_o(txd)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  int grant_log[$];
  int acc_cyc[$];
  logic [7:0] rx_log[$];
  logic [7:0] exp_q[$];
  bit m_busy = 0;
  int m_ptr = 0;
  int m_fc = 0;
  int m_owner = 0;
  logic [7:0] m_byte = '0;
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return N'(1) << ((p + i) % N);
    return '0;
  endfunction
  always @(negedge clk) begin
    logic e_txd;
    logic e_busy;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    int slot;
    if (rst) begin
      m_busy = 0;
      m_ptr = 0;
      m_fc = 0;
      exp_q.delete();
    end else begin
      if (m_busy) begin
        slot = m_fc / BV;
        e_txd = slot == 0 ? 1'b0 : slot == 9 ? 1'b1 : m_byte[slot-1];
        e_busy = 1'b1;
        e_grant = N'(1) << m_owner;
        e_ready = '0;
      end else begin
        e_txd = 1'b1;
        e_busy = 1'b0;
        e_grant = '0;
        e_ready = rr_pick(valid, m_ptr);
      end
      chk("txd", txd, e_txd);
      chk("busy", busy, e_busy);
      chk("grant", grant, e_grant);
      chk("ready", ready, e_ready);
      for (int k = 0; k < N; k++)
        if (ready[k] && valid[k]) begin
          grant_log.push_back(k);
          acc_cyc.push_back(cyc);
        end
      if (m_busy) begin
        m_fc++;
        if (m_fc == FRAME) m_busy = 0;
      end else if (e_ready != 0) begin
        for (int k = 0; k < N; k++) if (e_ready[k]) m_owner = k;
        m_busy = 1;
        m_fc = 0;
        m_ptr = (m_owner + 1) % N;
        m_byte = data[8*m_owner +: 8];
        exp_q.push_back(m_byte);
      end
    end
  end
  bit rx_on = 0;
  int rx_cnt = 0;
  logic [7:0] rx_b;
  always @(negedge clk) begin
    if (rst) rx_on = 0;
    else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1;
        rx_cnt = 1;
      end
    end else begin
      if (rx_cnt == 5) chk("rx_start", txd, 1'b0);
      if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_b[(rx_cnt - 15) / 10] = txd;
      if (rx_cnt == 95) begin
        chk("rx_stop", txd, 1'b1);
        rx_log.push_back(rx_b);
        if (exp_q.size() == 0) chk("rx_unexpected", rx_b, 32'hFFFF);
        else chk("rx_byte", rx_b, exp_q.pop_front());
        rx_on = 0;
      end
      rx_cnt++;
    end
  end
  logic [N-1:0] acc = '0;
  always @(negedge clk) acc = valid & ready;
  logic [7:0] src_mem[N][32];
  int src_n[N];
  int src_i[N];
  task automatic load(input int k);
    data[8*k +: 8] = src_mem[k][src_i[k]];
    src_i[k]++;
    valid[k] = 1'b1;
  endtask
  task automatic push(input int k, input logic [7:0] b);
    src_mem[k][src_n[k]] = b;
    src_n[k]++;
    if (!valid[k]) load(k);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (acc[k]) begin
          if (src_i[k] < src_n[k]) load(k);
          else valid[k] = 1'b0;
        end
    end
  endtask
  task automatic wait_idle();
    int g = 0;
    while ((valid != 0 || busy !== 1'b0) && g < 20000) begin
      step();
      g++;
    end
    if (g >= 20000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles want idle", g);
    end
    step(2);
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    valid = '0;
    for (int k = 0; k < N; k++) begin
      src_n[k] = 0;
      src_i[k] = 0;
    end
    step(3);
    rst = 1'b0;
  endtask
  task automatic clear_logs();
    grant_log.delete();
    acc_cyc.delete();
    rx_log.delete();
  endtask
  function automatic int glog(input int i);
    return i < grant_log.size() ? grant_log[i] : -1;
  endfunction
  function automatic int rlog(input int i);
    return i < rx_log.size() ? int'(rx_log[i]) : -1;
  endfunction
  localparam logic [9:0] BITS55 = 10'b1010101010;
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
  initial begin
    apply_reset();
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", ready, 0);
    push(0, 8'h55);
    #1;
    chk("t1_ready", ready, 4'b0001);
    step();
    chk("t1_ready_pulse", ready, 0);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1'b1);
    step(5);
    for (int s = 0; s < 10; s++) begin
      chk("t1_bit", txd, BITS55[s]);
      step(s == 9 ? 5 : 10);
    end
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_rx_n", rx_log.size(), 1);
    chk("t1_rx", rlog(0), 8'h55);
    apply_reset();
    clear_logs();
    for (int k = 0; k < N; k++) push(k, 8'(8'h41 + k));
    wait_idle();
    for (int k = 0; k < N; k++) begin
      chk("t2_order", glog(k), k);
      chk("t2_rx", rlog(k), 8'h41 + k);
    end
    for (int k = 1; k < N; k++)
      chk("t2_gap", k < acc_cyc.size() ? acc_cyc[k] - acc_cyc[k-1] : -1, FRAME + 1);
    apply_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 8'($urandom));
      push(2, 8'($urandom));
    end
    wait_idle();
    for (int i = 0; i < 8; i++) chk("t3_alt", glog(i), (i % 2) * 2);
    clear_logs();
    push(3, 8'h33);
    wait_idle();
    push(0, 8'h10);
    push(1, 8'h11);
    wait_idle();
    chk("t3_g3", glog(0), 3);
    chk("t3_wrap0", glog(1), 0);
    chk("t3_wrap1", glog(2), 1);
    clear_logs();
    push(0, 8'hF0);
    step(30);
    push(1, 8'hC3);
    begin
      int g = 0;
      while (busy === 1'b1 && g < 200) begin
        chk("t4_hold", ready, 0);
        step();
        g++;
      end
    end
    chk("t4_ready_idle", ready, 4'b0010);
    step();
    chk("t4_grant", grant, 4'b0010);
    wait_idle();
    chk("t4_rx0", rlog(0), 8'hF0);
    chk("t4_rx1", rlog(1), 8'hC3);
    clear_logs();
    push(0, 8'h5A);
    step();
    step(54);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_txd", txd, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_grant", grant, 0);
    step(2);
    rst = 1'b0;
    push(1, 8'h3C);
    push(0, 8'hA5);
    wait_idle();
    chk("t5_g_first", glog(1), 0);
    chk("t5_g_second", glog(2), 1);
    chk("t5_rx_n", rx_log.size(), 2);
    chk("t5_rx0", rlog(0), 8'hA5);
    chk("t5_rx1", rlog(1), 8'h3C);
    clear_logs();
    push(2, 8'h77);
    step(20);
    data[31:24] = 8'h99;
    valid[3] = 1'b1;
    step();
    valid[3] = 1'b0;
    wait_idle();
    for (int i = 0; i < 30; i++) begin
      chk("t6_idle_txd", txd, 1'b1);
      step();
    end
    chk("t6_n", grant_log.size(), 1);
    chk("t6_g", glog(0), 2);
    chk("t6_rx", rlog(0), 8'h77);
    clear_logs();
    for (int r = 0; r < 12; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (m[k]) push(k, 8'($urandom));
      step($urandom_range(0, 150));
    end
    wait_idle();
    chk("rand_rx_n", rx_log.size(), grant_log.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
